// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - borrow_in, BITS_PER_CYCLE bits per clock.
// Define SERIAL_SUBTRACTOR_SAT_EN to clamp an underflowing result to zero.
module serial_subtractor #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned NumSlices = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;

  if (WIDTH < 2 || BITS_PER_CYCLE == 0 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
    $error("serial_subtractor: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                    state_q;
  logic [WIDTH-1:0]          a_q, b_q, res_q;
  logic                      borrow_q;
  logic [CntW-1:0]           cnt_q;
  logic [BITS_PER_CYCLE-1:0] slice_d;
  logic                      slice_br;
  logic [WIDTH-1:0]          res_next;
  logic [WIDTH-1:0]          diff_next;

  // Ripple of borrow cells across the current (lowest) slice of the operand shift registers.
  always_comb begin
    logic br;
    slice_d = '0;
    br      = borrow_q;
    for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
      slice_d[j] = a_q[j] ^ b_q[j] ^ br;
      br         = (~a_q[j] & b_q[j]) | (~(a_q[j] ^ b_q[j]) & br);
    end
    slice_br = br;
  end

  // Slices enter at the top so the LSB slice ends up at bit 0 after the last shift.
  always_comb begin
    res_next = (res_q >> BITS_PER_CYCLE) | (WIDTH'(slice_d) << (WIDTH - BITS_PER_CYCLE));
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    diff_next = slice_br ? '0 : res_next;
`else
    diff_next = res_next;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      borrow_q   <= 1'b0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= borrow_in;
            res_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q      <= a_q >> BITS_PER_CYCLE;
          b_q      <= b_q >> BITS_PER_CYCLE;
          res_q    <= res_next;
          borrow_q <= slice_br;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CntW'(NumSlices - 1)) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= diff_next;
            borrow_out <= slice_br;
            state_q    <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: 8-bit instances with 1 and 4 bits per cycle.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, bi1, busy1, done1, bo1;
  logic [7:0] a1, b1, diff1;
  logic       start4, bi4, busy4, done4, bo4;
  logic [7:0] a4, b4, diff4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .borrow_in(bi1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .borrow_in(bi4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] exp_diff;  // wrap-around result
    logic       exp_bo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sat(input logic [7:0] d, input logic bo);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    return bo ? 8'h00 : d;
`else
    return d;
`endif
  endfunction

  // One operation on the 1-bit-per-cycle instance; poke > 0 re-asserts start in that RUN cycle.
  task automatic run1(input logic [7:0] ia, input logic [7:0] ib, input logic ibi,
                      input logic [7:0] ed, input logic ebo, input int poke, input string name);
    int cyc;
    bit seen;
    bit busy_ok;
    @(negedge clk);
    a1 = ia; b1 = ib; bi1 = ibi; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = ~ia; b1 = ib ^ 8'h5A; bi1 = ~ibi;
    chk({name, " busy after accept"}, 32'(busy1), 32'd1);
    cyc = 0; seen = 0; busy_ok = 1;
    while (!seen && cyc < 12) begin
      if (poke != 0 && cyc == poke) begin
        start1 = 1'b1; a1 = 8'h01; b1 = 8'h02;
      end else begin
        start1 = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (done1) seen = 1;
      else if (!busy1) busy_ok = 0;
    end
    start1 = 1'b0;
    chk({name, " done seen"}, 32'(seen), 32'd1);
    chk({name, " latency"}, 32'(cyc), 32'd8);
    chk({name, " busy held"}, 32'(busy_ok), 32'd1);
    chk({name, " busy low in done"}, 32'(busy1), 32'd0);
    chk({name, " diff"}, 32'(diff1), 32'(sat(ed, ebo)));
    chk({name, " borrow_out"}, 32'(bo1), 32'(ebo));
    @(posedge clk); #1;
    chk({name, " done one cycle"}, 32'(done1), 32'd0);
    chk({name, " diff held"}, 32'(diff1), 32'(sat(ed, ebo)));
  endtask

  vec_t vecs[8];

  initial begin
    int cyc;
    bit seen;
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1};
    vecs[6] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{8'h37, 8'h12, 1'b1, 8'h24, 1'b0};

    rst_n = 1'b0;
    start1 = 1'b0; a1 = 8'h00; b1 = 8'h00; bi1 = 1'b0;
    start4 = 1'b0; a4 = 8'h00; b4 = 8'h00; bi4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy1), 32'd0);
    chk("reset done", 32'(done1), 32'd0);
    chk("reset diff", 32'(diff1), 32'd0);
    chk("reset borrow_out", 32'(bo1), 32'd0);
    chk("reset busy4", 32'(busy4), 32'd0);
    chk("reset diff4", 32'(diff4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run1(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].exp_diff, vecs[i].exp_bo, 0,
           $sformatf("vec%0d", i));
    end

    // Start pulse in RUN cycle 3 must be ignored.
    run1(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 3, "ignore start");

    // Back-to-back on the 4-bit-slice instance: start held through DONE.
    @(negedge clk);
    a4 = 8'h80; b4 = 8'h01; bi4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    chk("bpc4 busy after accept", 32'(busy4), 32'd1);
    @(posedge clk); #1;
    chk("bpc4 busy mid", 32'(busy4), 32'd1);
    chk("bpc4 no early done", 32'(done4), 32'd0);
    a4 = 8'h30; b4 = 8'h05;
    @(posedge clk); #1;
    chk("bpc4 done at k+2", 32'(done4), 32'd1);
    chk("bpc4 diff", 32'(diff4), 32'h7F);
    chk("bpc4 borrow_out", 32'(bo4), 32'd0);
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 8'hFF; b4 = 8'hFF;
    chk("bpc4 b2b busy", 32'(busy4), 32'd1);
    chk("bpc4 b2b done low", 32'(done4), 32'd0);
    cyc = 0; seen = 0;
    while (!seen && cyc < 6) begin
      @(posedge clk); #1;
      cyc++;
      if (done4) seen = 1;
    end
    chk("bpc4 b2b latency", 32'(cyc), 32'd2);
    chk("bpc4 b2b diff", 32'(diff4), 32'h2B);
    chk("bpc4 b2b borrow_out", 32'(bo4), 32'd0);

    // Abort: reset in RUN cycle 4 clears outputs at once and yields no done pulse.
    @(negedge clk);
    a1 = 8'h10; b1 = 8'h20; bi1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre-abort diff held", 32'(diff1), 32'h1E);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy1), 32'd0);
    chk("abort done", 32'(done1), 32'd0);
    chk("abort diff", 32'(diff1), 32'd0);
    chk("abort borrow_out", 32'(bo1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done1 || busy1) seen = 1;
    end
    chk("no done after abort", 32'(seen), 32'd0);
    run1(8'h37, 8'h12, 1'b1, 8'h24, 1'b0, 0, "post-abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
